// File: rtl/dot_seq.sv
// Operand sequencer for the Newton-Raphson MAC: streams bank A/B pairs into the MAC and captures the Q8.24 sum.
// Optional macro DOT_CHAIN_EN adds start_acc, which chains a new call onto the MAC's held sum.
module dot_seq #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
`ifdef DOT_CHAIN_EN
  input  logic          start_acc,
`endif
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result,
  output logic          mac_new,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  input  logic [DW-1:0] mac_p
);

  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t        state_q;
  logic [DW-1:0] bank_a_q [DEPTH];
  logic [DW-1:0] bank_b_q [DEPTH];
  logic [AW:0]   len_q;
  logic [AW:0]   idx_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          mac_new_q;
  logic [DW-1:0] mac_a_q;
  logic [DW-1:0] mac_b_q;
  logic [DW-1:0] result_q;
  logic          len_ok;
  logic          first_new;

  assign len_ok = (len != '0) && (len <= LEN_MAX);

`ifdef DOT_CHAIN_EN
  assign first_new = ~start_acc;
`else
  assign first_new = 1'b1;
`endif

  // Banks only change while idle so a running sequence always sees a stable operand set.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      if (wr_bank) bank_b_q[wr_addr] <= wr_data;
      else         bank_a_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mac_new_q <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_q   <= ISSUE;
              len_q     <= len;
              idx_q     <= IDX_ONE;
              mac_a_q   <= bank_a_q[0];
              mac_b_q   <= bank_b_q[0];
              mac_new_q <= first_new;
              busy_q    <= 1'b1;
              err_q     <= 1'b0;
            end else begin
              state_q  <= FIN;
              err_q    <= 1'b1;
              result_q <= '0;
              done_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          mac_new_q <= 1'b0;
          // Zero operands after the last term keep the free-running MAC sum frozen.
          if (idx_q == len_q) begin
            state_q <= DRAIN;
            mac_a_q <= '0;
            mac_b_q <= '0;
          end else begin
            mac_a_q <= bank_a_q[idx_q[AW-1:0]];
            mac_b_q <= bank_b_q[idx_q[AW-1:0]];
            idx_q   <= idx_q + IDX_ONE;
          end
        end
        DRAIN: begin
          result_q <= mac_p;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= FIN;
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign result  = result_q;
  assign mac_new = mac_new_q;
  assign mac_a   = mac_a_q;
  assign mac_b   = mac_b_q;

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq: behavioural Q8.24 MAC plus table, corner-case and random runs.
// Build with DOT_CHAIN_EN defined to also exercise chained accumulation.
module tb_dot_seq;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_bank = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
`ifdef DOT_CHAIN_EN
  logic          start_acc = 1'b0;
`endif
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] result;
  logic          mac_new;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [DW-1:0] mac_p = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] ma [8];
  logic [DW-1:0] mb [8];

  always #5 clk = ~clk;

  dot_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len),
`ifdef DOT_CHAIN_EN
    .start_acc(start_acc),
`endif
    .busy(busy), .done(done), .err(err), .result(result),
    .mac_new(mac_new), .mac_a(mac_a), .mac_b(mac_b), .mac_p(mac_p)
  );

  // Environment model of the MAC: accumulates a Q8.24 product every cycle, restarting on newMac.
  always @(posedge clk) begin
    longint pr;
    pr = (longint'($signed(mac_a)) * longint'($signed(mac_b))) >>> 24;
    if (!rst_n)       mac_p <= '0;
    else if (mac_new) mac_p <= pr[31:0];
    else              mac_p <= mac_p + pr[31:0];
  end

  function automatic logic [31:0] ref_dot(input int n, input logic [31:0] base);
    logic [31:0] acc;
    longint p;
    acc = base;
    for (int k = 0; k < n; k++) begin
      p = (longint'($signed(ma[k])) * longint'($signed(mb[k]))) >>> 24;
      acc = acc + p[31:0];
    end
    return acc;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic bk, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_bank = bk; wr_addr = ad; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (bk) mb[ad] = d;
    else    ma[ad] = d;
  endtask

  task automatic do_run(input logic [AW:0] l, output int lat, output int n_new,
                        output int busy_cyc, output logic [31:0] res, output logic e);
    lat = -1; n_new = 0; busy_cyc = 0; res = '0; e = 1'b0;
    @(negedge clk);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mac_new) n_new++;
      if (busy) busy_cyc++;
      if (done) begin
        lat = c; res = result; e = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [AW:0]   len;
    logic [DW-1:0] a [3];
    logic [DW-1:0] b [3];
    logic [DW-1:0] exp_res;
    logic          exp_err;
    int            exp_lat;
    int            exp_new;
    int            exp_busy;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int lat, nn, bc, nd, bad;
    logic [31:0] res;
    logic e;
    logic [AW:0] l;
    logic legal;

    tbl[0].len = 4'd3; tbl[0].a = '{32'h01000000, 32'h02000000, 32'h00800000};
    tbl[0].b = '{32'h01000000, 32'h01000000, 32'h02000000};
    tbl[0].exp_res = 32'h04000000; tbl[0].exp_err = 1'b0; tbl[0].exp_lat = 5; tbl[0].exp_new = 1; tbl[0].exp_busy = 4;
    tbl[1].len = 4'd1; tbl[1].a = '{32'hFE800000, 32'h0, 32'h0};
    tbl[1].b = '{32'h02000000, 32'h0, 32'h0};
    tbl[1].exp_res = 32'hFD000000; tbl[1].exp_err = 1'b0; tbl[1].exp_lat = 3; tbl[1].exp_new = 1; tbl[1].exp_busy = 2;
    tbl[2].len = 4'd0; tbl[2].a = '{32'h01000000, 32'h01000000, 32'h01000000};
    tbl[2].b = '{32'h01000000, 32'h01000000, 32'h01000000};
    tbl[2].exp_res = 32'h0; tbl[2].exp_err = 1'b1; tbl[2].exp_lat = 1; tbl[2].exp_new = 0; tbl[2].exp_busy = 0;
    tbl[3].len = 4'd9; tbl[3].a = '{32'h01000000, 32'h01000000, 32'h01000000};
    tbl[3].b = '{32'h01000000, 32'h01000000, 32'h01000000};
    tbl[3].exp_res = 32'h0; tbl[3].exp_err = 1'b1; tbl[3].exp_lat = 1; tbl[3].exp_new = 0; tbl[3].exp_busy = 0;
    tbl[4].len = 4'd2; tbl[4].a = '{32'h01000000, 32'h00400000, 32'h0};
    tbl[4].b = '{32'h03000000, 32'hFFC00000, 32'h0};
    tbl[4].exp_res = 32'h02F00000; tbl[4].exp_err = 1'b0; tbl[4].exp_lat = 4; tbl[4].exp_new = 1; tbl[4].exp_busy = 3;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {28'd0, busy, done, err, mac_new}, 32'h0);
    chk("reset_mac_a", mac_a, 32'h0);
    chk("reset_mac_b", mac_b, 32'h0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) begin
        wr(1'b0, 3'(k), tbl[i].a[k]);
        wr(1'b1, 3'(k), tbl[i].b[k]);
      end
      do_run(tbl[i].len, lat, nn, bc, res, e);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].exp_res);
      chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_mac_new_count", i), nn, tbl[i].exp_new);
      chk($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].exp_busy);
      @(negedge clk);
      chk($sformatf("tbl%0d_done_one_cycle", i), {31'd0, done}, 32'h0);
    end

    // Signed single term, then the MAC sum must stay frozen while idle
    wr(1'b0, 3'd0, 32'hFE800000);
    wr(1'b1, 3'd0, 32'h02000000);
    do_run(4'd1, lat, nn, bc, res, e);
    chk("signed_result", res, 32'hFD000000);
    chk("signed_latency", lat, 3);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mac_p !== 32'hFD000000 || mac_a !== '0 || mac_b !== '0 || mac_new !== 1'b0) bad++;
    end
    chk("signed_hold_idle_cycles_bad", bad, 0);

    // Busy interlock: start and a bank write during ISSUE are both ignored
    wr(1'b0, 3'd0, 32'h01000000); wr(1'b0, 3'd1, 32'h02000000); wr(1'b0, 3'd2, 32'h00800000);
    wr(1'b1, 3'd0, 32'h01000000); wr(1'b1, 3'd1, 32'h01000000); wr(1'b1, 3'd2, 32'h02000000);
    @(negedge clk);
    start = 1'b1; len = 4'd3;
    @(negedge clk);
    wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 3'd0; wr_data = 32'h7F000000;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("interlock_done_count", nd, 1);
    do_run(4'd3, lat, nn, bc, res, e);
    chk("interlock_bank_unchanged_result", res, 32'h04000000);

    // Reset in the middle of ISSUE
    @(negedge clk);
    start = 1'b1; len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_before", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", {28'd0, busy, done, err, mac_new}, 32'h0);
    chk("rst_mid_mac_a", mac_a, 32'h0);
    chk("rst_mid_mac_b", mac_b, 32'h0);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_mid_no_done", nd, 0);
    do_run(4'd3, lat, nn, bc, res, e);
    chk("rst_mid_rerun_result", res, 32'h04000000);
    chk("rst_mid_rerun_latency", lat, 5);

`ifdef DOT_CHAIN_EN
    // Chained call adds onto the previous sum instead of restarting it
    do_run(4'd3, lat, nn, bc, res, e);
    chk("chain_first_result", res, 32'h04000000);
    start_acc = 1'b1;
    do_run(4'd1, lat, nn, bc, res, e);
    start_acc = 1'b0;
    chk("chain_result", res, ref_dot(1, 32'h04000000));
    chk("chain_result_const", res, 32'h05000000);
    chk("chain_mac_new_count", nn, 0);
    chk("chain_latency", lat, 3);
`endif

    // Randomized runs against the arithmetic reference
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 8; k++) begin
        wr(1'b0, 3'(k), $urandom());
        wr(1'b1, 3'(k), $urandom());
      end
      if (it % 11 == 10)     l = 4'd0;
      else if (it % 6 == 5)  l = 4'($urandom_range(9, 15));
      else                   l = 4'($urandom_range(1, 8));
      legal = (l >= 4'd1) && (l <= 4'd8);
      do_run(l, lat, nn, bc, res, e);
      chk($sformatf("rnd%0d_result", it), res, legal ? ref_dot(int'(l), 32'h0) : 32'h0);
      chk($sformatf("rnd%0d_err", it), {31'd0, e}, {31'd0, ~legal});
      chk($sformatf("rnd%0d_latency", it), lat, legal ? int'(l) + 2 : 1);
      chk($sformatf("rnd%0d_mac_new_count", it), nn, legal ? 1 : 0);
      chk($sformatf("rnd%0d_busy_cycles", it), bc, legal ? int'(l) + 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
